collision_event_gen: RTL and testbench
======================================

Name: collision_event_gen

Overview:
- Source side of the collision interface. Turns the two raw collision buttons into clean, single-cycle goodColl/badColl pulses for the score display/tracker.
- Per input it synchronises, debounces and edge-detects the button. It then arbitrates simultaneous events and enforces a minimum gap between pulses.
- It tracks the game state (running / over) so that no events reach the tracker after the game has ended.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must differ from its debounced state before the state flips; legal range >=2.
- HOLDOFF_CYCLES, 4, idle cycles forced after every emitted pulse; legal range >=1.
- MAX_SCORE, 50, goodColl count per game at which the game ends without a badColl.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- good_btn_raw  input  1  raw good-collision button, asynchronous to clk
- bad_btn_raw  input  1  raw bad-collision button, asynchronous to clk
- goodColl  output  1  one-cycle good-collision pulse, registered
- badColl  output  1  one-cycle bad-collision pulse, registered
- game_over  output  1  high while in state OVER, registered
- good_count  output  8  goodColl pulses emitted in the current game, registered
- event_dropped  output  1  one-cycle pulse when a detected edge is discarded, registered

Behaviour:
- Reset (async, rst=1): all synchronisers, debounced states, counters, pending flags and outputs are 0; FSM = RUN.
  - A button held through reset release produces one edge after the normal debounce latency.
- Synchroniser: two flops per input. Edge 0 is the first edge that samples raw=1; sync output is 1 after edge 1.
- Debounce, per input:
  - Counter increments while sync != stable and clears when they are equal.
  - When counter == DEBOUNCE_CYCLES-1 and sync still differs: stable <= sync, counter <= 0.
  - stable therefore flips at edge DEBOUNCE_CYCLES+1.
- Edge detect: rise = (next stable) & ~stable. A rise sets pending_good / pending_bad at the same edge the stable state flips.
- Latency: with a clean button and FSM idle in RUN, the pulse output is high for exactly one cycle, registered at edge DEBOUNCE_CYCLES+2.
- FSM states RUN, HOLDOFF, OVER:
  - RUN, pending_bad:
    - emit badColl and clear both pending flags.
    - If pending_good was also set, pulse event_dropped (bad has priority).
    - Go to HOLDOFF with the over flag set.
  - RUN, only pending_good: emit goodColl, good_count+1, clear pending_good, go to HOLDOFF.
    - If the incremented count == MAX_SCORE, set the over flag.
  - HOLDOFF: stay for HOLDOFF_CYCLES cycles, then go to OVER if the over flag is set, else RUN.
    - Pending flags keep accumulating here.
    - The next pulse is no earlier than E+HOLDOFF_CYCLES+1, where E is the previous pulse edge.
  - OVER:
    - bad rises are discarded silently (no event_dropped).
    - A good rise emits goodColl (restart), sets good_count=1, clears the over flag and goes to HOLDOFF.
- Merging: a rise on an input whose pending flag is already set is lost and pulses event_dropped.
- goodColl and badColl are never high in the same cycle.
- good_count: 8-bit, saturates at 255, cleared on reset and on a restart before being set to 1.
- Pulse output timing: all outputs change only on the clock edge. Pulse outputs are 0 in every cycle not explicitly listed above.

Decomposition:
- Package snake_pkg:
  - typedef enum logic [1:0] {RUN, HOLDOFF, OVER} coll_state_t
  - localparam SCORE_W = 8
  - default parameter constants
- Sub-module btn_debounce (clk, rst, raw, DEBOUNCE_CYCLES): 2-flop sync + debounce counter. Outputs stable and rise. Instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=3, MAX_SCORE=3):
- Latency: raise good_btn_raw sampled at edge 0, hold for 20 cycles -> goodColl high only after edge 6; good_count=1; no further pulse while held.
- Bounce: toggle good_btn_raw every 2 cycles for 16 cycles, then hold low -> no goodColl, good_count stays 0.
- Priority: both raws rise at the same edge and are held -> badColl after edge 6, event_dropped in the same cycle, no goodColl; game_over=1 after edge 10.
- Holdoff/merge: with good stable, release it and press again so its rise lands 1 cycle after the first pulse -> second goodColl exactly 4 cycles after the first. A third rise arriving while pending is set -> event_dropped, no third pulse.
- MAX_SCORE: three spaced good presses -> good_count=3 and game_over after the holdoff. A bad press then gives no badColl. A fourth good press -> goodColl, good_count=1, game_over=0.
- Reset mid-operation: assert rst during HOLDOFF with pending_bad set -> all outputs 0 immediately; after release, a held bad button yields a single badColl after edge 6 relative to reset release.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and defaults for the collision event source.
package snake_pkg;

  typedef enum logic [1:0] {RUN, HOLDOFF, OVER} coll_state_t;

  localparam int SCORE_W = 8;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_HOLDOFF_CYCLES  = 4;
  localparam int DEF_MAX_SCORE       = 50;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce counter for one raw button.
// rise is combinational and coincides with the edge at which stable flips high.
module btn_debounce
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             flip;

  assign differ = sync_2 ^ stable;
  assign flip   = differ && (cnt == CNT_LAST);
  assign rise   = flip & sync_2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (!differ) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= sync_2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/collision_event_gen.sv
// Turns the two raw collision buttons into clean goodColl/badColl pulses,
// arbitrating, spacing them out and blocking events once the game is over.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   RUN     | game running, idle; emits the next pending event (bad first)
//   HOLDOFF | forced gap after a pulse; pending flags keep accumulating
//   OVER    | game ended; bad rises ignored, a good rise restarts the game
module collision_event_gen
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
  parameter int MAX_SCORE       = DEF_MAX_SCORE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               good_btn_raw,
  input  logic               bad_btn_raw,
  output logic               goodColl,
  output logic               badColl,
  output logic               game_over,
  output logic [SCORE_W-1:0] good_count,
  output logic               event_dropped
);

  localparam int TMR_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(HOLDOFF_CYCLES - 1);
  localparam logic [SCORE_W-1:0] MAX_CNT  = SCORE_W'(MAX_SCORE);

  logic good_stable, good_rise;
  logic bad_stable, bad_rise;
  logic unused_stable;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_good_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (good_btn_raw),
    .stable (good_stable),
    .rise   (good_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bad_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (bad_btn_raw),
    .stable (bad_stable),
    .rise   (bad_rise)
  );

  // Only the rise strobes drive the FSM; the levels are not needed here.
  assign unused_stable = good_stable ^ bad_stable;

  coll_state_t        state, state_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic               pend_good, pend_good_n;
  logic               pend_bad, pend_bad_n;
  logic               over_flag, over_n;
  logic [SCORE_W-1:0] count_n, inc;
  logic               good_n, bad_n, drop_n;
  logic               clr_good, clr_bad;

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    over_n      = over_flag;
    count_n     = good_count;
    good_n      = 1'b0;
    bad_n       = 1'b0;
    drop_n      = 1'b0;
    clr_good    = 1'b0;
    clr_bad     = 1'b0;
    pend_good_n = pend_good;
    pend_bad_n  = pend_bad;
    inc         = sat_inc(good_count);

    case (state)
      RUN: begin
        if (pend_bad) begin
          bad_n    = 1'b1;
          clr_good = 1'b1;
          clr_bad  = 1'b1;
          drop_n   = pend_good;
          over_n   = 1'b1;
          state_n  = HOLDOFF;
          timer_n  = TMR_LOAD;
        end else if (pend_good) begin
          good_n   = 1'b1;
          clr_good = 1'b1;
          count_n  = inc;
          if (inc == MAX_CNT) over_n = 1'b1;
          state_n  = HOLDOFF;
          timer_n  = TMR_LOAD;
        end
      end
      HOLDOFF: begin
        if (timer == '0) state_n = over_flag ? OVER : RUN;
        else             timer_n = timer - TMR_W'(1);
      end
      OVER: begin
        clr_bad = 1'b1;
        if (pend_good) begin
          good_n   = 1'b1;
          clr_good = 1'b1;
          count_n  = SCORE_W'(1);
          over_n   = 1'b0;
          state_n  = HOLDOFF;
          timer_n  = TMR_LOAD;
        end
      end
      default: state_n = RUN;
    endcase

    // A rise landing on an already-pending flag is merged away and reported.
    pend_good_n = (pend_good & ~clr_good) | good_rise;
    if (good_rise & pend_good & ~clr_good) drop_n = 1'b1;

    if (state == OVER) begin
      pend_bad_n = 1'b0;
    end else begin
      pend_bad_n = (pend_bad & ~clr_bad) | bad_rise;
      if (bad_rise & pend_bad & ~clr_bad) drop_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      timer         <= '0;
      pend_good     <= 1'b0;
      pend_bad      <= 1'b0;
      over_flag     <= 1'b0;
      good_count    <= '0;
      goodColl      <= 1'b0;
      badColl       <= 1'b0;
      event_dropped <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      pend_good     <= pend_good_n;
      pend_bad      <= pend_bad_n;
      over_flag     <= over_n;
      good_count    <= count_n;
      goodColl      <= good_n;
      badColl       <= bad_n;
      event_dropped <= drop_n;
      game_over     <= (state == OVER);
    end
  end

endmodule

// File: tb/tb_collision_event_gen.sv
// Scoreboard bench for collision_event_gen: expected pulses are queued by the
// stimulus and popped by monitors whenever a DUT raises a pulse output.
module tb_collision_event_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       good_btn_raw;
  logic       bad_btn_raw;

  logic       good_coll, bad_coll, game_over, event_dropped;
  logic [7:0] good_count;
  logic       good_coll_2, bad_coll_2, game_over_2, event_dropped_2;
  logic [7:0] good_count_2;

  // Main instance uses the short holdoff; the second has a long holdoff so
  // that two rises of the same button can land inside one holdoff window.
  collision_event_gen #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(3), .MAX_SCORE(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .good_btn_raw  (good_btn_raw),
    .bad_btn_raw   (bad_btn_raw),
    .goodColl      (good_coll),
    .badColl       (bad_coll),
    .game_over     (game_over),
    .good_count    (good_count),
    .event_dropped (event_dropped)
  );

  collision_event_gen #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(20), .MAX_SCORE(3)) dut_long (
    .clk           (clk),
    .rst           (rst),
    .good_btn_raw  (good_btn_raw),
    .bad_btn_raw   (bad_btn_raw),
    .goodColl      (good_coll_2),
    .badColl       (bad_coll_2),
    .game_over     (game_over_2),
    .good_count    (good_count_2),
    .event_dropped (event_dropped_2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [2:0] K_GOOD     = 3'b100;
  localparam logic [2:0] K_BAD      = 3'b010;
  localparam logic [2:0] K_DROP     = 3'b001;
  localparam logic [2:0] K_BAD_DROP = 3'b011;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
    int         cnt;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   checks = 0;
  int   errors = 0;
  bit   mon2_en = 1'b0;
  int   n;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic exp1(input logic [2:0] k, input int c, input int cnt);
    q1.push_back('{kind: k, cyc: c, cnt: cnt});
  endtask

  task automatic exp2(input logic [2:0] k, input int c, input int cnt);
    q2.push_back('{kind: k, cyc: c, cnt: cnt});
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    good_btn_raw = 1'b0;
    bad_btn_raw  = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(2);
  endtask

  task automatic end_test(input string name);
    chk({name, "_missing_pulses"}, q1.size(), 0);
    chk({name, "_missing_pulses_long"}, q2.size(), 0);
    q1.delete();
    q2.delete();
  endtask

  always @(negedge clk) begin
    if (good_coll | bad_coll | event_dropped) begin
      if (q1.size() == 0) begin
        chk("unexpected_pulse", {good_coll, bad_coll, event_dropped}, 0);
      end else begin
        e1 = q1.pop_front();
        chk("pulse_kind", {good_coll, bad_coll, event_dropped}, e1.kind);
        chk("pulse_cycle", cyc, e1.cyc);
        chk("pulse_count", good_count, e1.cnt);
      end
    end
  end

  always @(negedge clk) begin
    if (mon2_en && (good_coll_2 | bad_coll_2 | event_dropped_2)) begin
      if (q2.size() == 0) begin
        chk("long_unexpected_pulse", {good_coll_2, bad_coll_2, event_dropped_2}, 0);
      end else begin
        e2 = q2.pop_front();
        chk("long_pulse_kind", {good_coll_2, bad_coll_2, event_dropped_2}, e2.kind);
        chk("long_pulse_cycle", cyc, e2.cyc);
        chk("long_pulse_count", good_count_2, e2.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    good_btn_raw = 1'b0;
    bad_btn_raw  = 1'b0;
    cycles(3);
    chk("reset_goodColl", good_coll, 0);
    chk("reset_badColl", bad_coll, 0);
    chk("reset_game_over", game_over, 0);
    chk("reset_good_count", good_count, 0);
    chk("reset_event_dropped", event_dropped, 0);
    rst = 1'b0;
    cycles(2);

    // Latency: one pulse after relative edge 6, none while held.
    n = cyc;
    good_btn_raw = 1'b1;
    exp1(K_GOOD, n + 7, 1);
    cycles(20);
    chk("latency_count", good_count, 1);
    good_btn_raw = 1'b0;
    cycles(10);
    chk("latency_count_after_release", good_count, 1);
    end_test("latency");

    // Bounce: 2-cycle glitches never survive a 4-cycle debounce.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      good_btn_raw = (i % 2 == 0);
      cycles(2);
    end
    good_btn_raw = 1'b0;
    cycles(12);
    chk("bounce_count", good_count, 0);
    end_test("bounce");

    // Priority: simultaneous rises -> bad wins, good dropped, game over.
    do_reset();
    n = cyc;
    good_btn_raw = 1'b1;
    bad_btn_raw  = 1'b1;
    exp1(K_BAD_DROP, n + 7, 0);
    cycles(10);
    chk("priority_game_over_early", game_over, 0);
    cycles(1);
    chk("priority_game_over", game_over, 1);
    cycles(10);
    good_btn_raw = 1'b0;
    bad_btn_raw  = 1'b0;
    cycles(10);
    bad_btn_raw = 1'b1;
    cycles(8);
    bad_btn_raw = 1'b0;
    cycles(10);
    chk("over_bad_ignored_game_over", game_over, 1);
    n = cyc;
    good_btn_raw = 1'b1;
    exp1(K_GOOD, n + 7, 1);
    cycles(7);
    chk("restart_game_over_still", game_over, 1);
    cycles(1);
    chk("restart_game_over_clear", game_over, 0);
    chk("restart_count", good_count, 1);
    cycles(10);
    good_btn_raw = 1'b0;
    cycles(10);
    end_test("priority_restart");

    // Three spaced presses: MAX_SCORE on the main DUT, merge/drop on the long one.
    do_reset();
    mon2_en = 1'b1;
    n = cyc;
    exp1(K_GOOD, n + 7, 1);
    exp1(K_GOOD, n + 16, 2);
    exp1(K_GOOD, n + 25, 3);
    exp2(K_GOOD, n + 7, 1);
    exp2(K_DROP, n + 24, 1);
    exp2(K_GOOD, n + 28, 2);
    good_btn_raw = 1'b1; cycles(5);
    good_btn_raw = 1'b0; cycles(4);
    good_btn_raw = 1'b1; cycles(5);
    good_btn_raw = 1'b0; cycles(4);
    good_btn_raw = 1'b1;
    cycles(10);
    chk("max_game_over_early", game_over, 0);
    cycles(1);
    chk("max_game_over", game_over, 1);
    chk("max_count", good_count, 3);
    cycles(5);
    good_btn_raw = 1'b0;
    cycles(20);
    chk("merge_long_count", good_count_2, 2);
    chk("merge_long_game_over", game_over_2, 0);
    end_test("max_merge");
    mon2_en = 1'b0;

    // Holdoff spacing: bad rise one cycle after a good pulse comes out at E+4.
    do_reset();
    n = cyc;
    good_btn_raw = 1'b1;
    exp1(K_GOOD, n + 7, 1);
    exp1(K_BAD, n + 11, 1);
    cycles(2);
    bad_btn_raw = 1'b1;
    cycles(20);
    chk("holdoff_game_over", game_over, 1);
    good_btn_raw = 1'b0;
    bad_btn_raw  = 1'b0;
    cycles(8);
    end_test("holdoff");

    // Reset in HOLDOFF with pending_bad set, then a held bad button.
    do_reset();
    n = cyc;
    good_btn_raw = 1'b1;
    exp1(K_GOOD, n + 7, 1);
    cycles(2);
    bad_btn_raw = 1'b1;
    cycles(6);
    chk("midreset_pre_count", good_count, 1);
    rst = 1'b1;
    good_btn_raw = 1'b0;
    #1;
    chk("midreset_count", good_count, 0);
    chk("midreset_goodColl", good_coll, 0);
    chk("midreset_badColl", bad_coll, 0);
    chk("midreset_game_over", game_over, 0);
    chk("midreset_event_dropped", event_dropped, 0);
    cycles(3);
    n = cyc;
    exp1(K_BAD, n + 7, 0);
    rst = 1'b0;
    cycles(15);
    chk("midreset_game_over_after", game_over, 1);
    bad_btn_raw = 1'b0;
    cycles(8);
    end_test("midreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
